// File: rtl/cunit_pipe.sv
// cunit_pipe: RV32I(+M) control unit for a 5-stage pipeline.
// It decodes the ID-stage instruction and carries the control word through the ID/EX, EX/MEM and MEM/WB registers.
// Latency: EX fields are valid 1 cycle after ID, MEM fields after 2, WB fields after 3.
// Backpressure: stall_if_id holds PC and IF/ID on a load-use hazard or while a multi-cycle divide occupies EX.
// Ports: clk/rst; ID instruction fields OpCode/Funct3/Funct7/Rs1/Rs2/Rd; flush from the EX branch unit;
//        id_* combinational decode; stall_if_id/ex_busy hazard status; ex_*/mem_*/wb_* registered stage controls.
module cunit_pipe #(
  parameter int MEXT    = 1,
  parameter int DIV_LAT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] OpCode,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  input  logic [4:0] Rs1,
  input  logic [4:0] Rs2,
  input  logic [4:0] Rd,
  input  logic       flush,
  output logic [2:0] id_ImmSrc,
  output logic       id_illegal,
  output logic       stall_if_id,
  output logic       ex_busy,
  output logic       ex_ALUASrc,
  output logic       ex_ALUBSrc,
  output logic [4:0] ex_ALUOp,
  output logic [4:0] ex_BUOp,
  output logic [4:0] ex_Rd,
  output logic       mem_DMWr,
  output logic       mem_DMrd,
  output logic [2:0] mem_DMCtrl,
  output logic [4:0] mem_Rd,
  output logic [1:0] wb_RUDatawrSrc,
  output logic       wb_RuWr,
  output logic [4:0] wb_Rd
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_MEXT   = 7'b0000001;

  localparam bit         HAS_M    = (MEXT != 0);
  localparam logic [5:0] DIV_INIT = 6'(DIV_LAT - 1);

  // Each stage register keeps only the fields that later stages still need.
  typedef struct packed {
    logic       asrc;
    logic       bsrc;
    logic [4:0] aluop;
    logic [4:0] buop;
    logic       dmwr;
    logic       dmrd;
    logic [2:0] dmctrl;
    logic [1:0] wrsrc;
    logic       ruwr;
    logic [4:0] rd;
  } ex_t;

  typedef struct packed {
    logic       dmwr;
    logic       dmrd;
    logic [2:0] dmctrl;
    logic [1:0] wrsrc;
    logic       ruwr;
    logic [4:0] rd;
  } mem_t;

  typedef struct packed {
    logic [1:0] wrsrc;
    logic       ruwr;
    logic [4:0] rd;
  } wb_t;

  ex_t        dec;
  logic [2:0] imm_src;
  logic       use_rs1, use_rs2, is_div, illegal;

  ex_t        ex_q;
  mem_t       mem_q;
  wb_t        wb_q;
  logic [5:0] div_cnt;
  logic       pending_flush;

  logic       kill, load_use;

  // ---------------- ID decode ----------------
  always_comb begin
    dec     = '0;
    imm_src = 3'b000;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    is_div  = 1'b0;
    illegal = 1'b0;
    case (OpCode)
      OP_R: begin
        if (Funct7 == F7_MEXT && !HAS_M) begin
          illegal = 1'b1;
        end else begin
          dec.ruwr = 1'b1;
          use_rs1  = 1'b1;
          use_rs2  = 1'b1;
          if (Funct7 == F7_MEXT) begin
            dec.aluop = {2'b10, Funct3};
            is_div    = Funct3[2];        // div/divu/rem/remu
          end else begin
            dec.aluop = {1'b0, Funct7[5], Funct3};
          end
        end
      end
      OP_I: begin
        dec.bsrc  = 1'b1;
        dec.ruwr  = 1'b1;
        use_rs1   = 1'b1;
        // Only srai uses Funct7[5]; for other I ops those bits are immediate.
        dec.aluop = {1'b0, (Funct3 == 3'b101) ? Funct7[5] : 1'b0, Funct3};
      end
      OP_LOAD: begin
        dec.bsrc   = 1'b1;
        dec.dmctrl = Funct3;
        dec.wrsrc  = 2'b01;
        dec.ruwr   = 1'b1;
        dec.dmrd   = 1'b1;
        use_rs1    = 1'b1;
      end
      OP_STORE: begin
        imm_src    = 3'b001;
        dec.bsrc   = 1'b1;
        dec.dmwr   = 1'b1;
        dec.dmctrl = Funct3;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_BRANCH: begin
        imm_src  = 3'b101;
        dec.asrc = 1'b1;
        dec.bsrc = 1'b1;
        dec.buop = {2'b01, Funct3};
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OP_JAL: begin
        imm_src   = 3'b110;
        dec.asrc  = 1'b1;
        dec.bsrc  = 1'b1;
        dec.wrsrc = 2'b10;
        dec.ruwr  = 1'b1;
        dec.buop  = 5'b10000;
      end
      OP_JALR: begin
        dec.bsrc  = 1'b1;
        dec.wrsrc = 2'b10;
        dec.ruwr  = 1'b1;
        dec.buop  = 5'b10000;
        use_rs1   = 1'b1;
      end
      OP_LUI: begin
        imm_src   = 3'b011;
        dec.asrc  = 1'b1;
        dec.bsrc  = 1'b1;
        dec.aluop = 5'b01111;             // ALU passes operand B
        dec.ruwr  = 1'b1;
      end
      OP_AUIPC: begin
        imm_src  = 3'b011;
        dec.asrc = 1'b1;
        dec.bsrc = 1'b1;
        dec.ruwr = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    // An illegal instruction becomes a full bubble, destination included.
    dec.rd = illegal ? 5'd0 : Rd;
  end

  // ---------------- hazards ----------------
  assign ex_busy  = (div_cnt != 6'd0);
  assign kill     = flush | pending_flush;
  assign load_use = ex_q.dmrd && (ex_q.rd != 5'd0) &&
                    ((use_rs1 && (Rs1 == ex_q.rd)) || (use_rs2 && (Rs2 == ex_q.rd)));
  // A flush discards the ID instruction anyway, so it overrides the load-use stall.
  assign stall_if_id = ex_busy | (load_use & ~kill);

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      div_cnt       <= 6'd0;
      pending_flush <= 1'b0;
    end else begin
      wb_q <= '{wrsrc: mem_q.wrsrc, ruwr: mem_q.ruwr, rd: mem_q.rd};
      if (ex_busy) begin
        // Divider holds EX; MEM sees bubbles, and a flush is remembered.
        mem_q   <= '0;
        div_cnt <= div_cnt - 6'd1;
        if (flush) pending_flush <= 1'b1;
      end else begin
        mem_q <= '{dmwr: ex_q.dmwr, dmrd: ex_q.dmrd, dmctrl: ex_q.dmctrl,
                   wrsrc: ex_q.wrsrc, ruwr: ex_q.ruwr, rd: ex_q.rd};
        pending_flush <= 1'b0;
        if (kill || load_use) begin
          ex_q <= '0;
        end else begin
          ex_q <= dec;
          // DIV_INIT is 0 for a single-cycle divider, so it never goes busy.
          if (is_div) div_cnt <= DIV_INIT;
        end
      end
    end
  end

  // ---------------- outputs ----------------
  assign id_ImmSrc      = imm_src;
  assign id_illegal     = illegal;
  assign ex_ALUASrc     = ex_q.asrc;
  assign ex_ALUBSrc     = ex_q.bsrc;
  assign ex_ALUOp       = ex_q.aluop;
  assign ex_BUOp        = ex_q.buop;
  assign ex_Rd          = ex_q.rd;
  assign mem_DMWr       = mem_q.dmwr;
  assign mem_DMrd       = mem_q.dmrd;
  assign mem_DMCtrl     = mem_q.dmctrl;
  assign mem_Rd         = mem_q.rd;
  assign wb_RUDatawrSrc = wb_q.wrsrc;
  assign wb_RuWr        = wb_q.ruwr;
  assign wb_Rd          = wb_q.rd;

endmodule

// File: tb/tb_cunit_pipe.sv
module tb_cunit_pipe;

  localparam int DIV_LAT = 8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] OpCode = '0;
  logic [2:0] Funct3 = '0;
  logic [6:0] Funct7 = '0;
  logic [4:0] Rs1 = '0, Rs2 = '0, Rd = '0;
  logic       flush = 1'b0;

  logic [2:0] id_ImmSrc;
  logic       id_illegal, stall_if_id, ex_busy, ex_ALUASrc, ex_ALUBSrc;
  logic [4:0] ex_ALUOp, ex_BUOp, ex_Rd;
  logic       mem_DMWr, mem_DMrd;
  logic [2:0] mem_DMCtrl;
  logic [4:0] mem_Rd;
  logic [1:0] wb_RUDatawrSrc;
  logic       wb_RuWr;
  logic [4:0] wb_Rd;

  logic [2:0] n_id_ImmSrc;
  logic       n_id_illegal, n_stall_if_id, n_ex_busy, n_ex_ALUASrc, n_ex_ALUBSrc;
  logic [4:0] n_ex_ALUOp, n_ex_BUOp, n_ex_Rd;
  logic       n_mem_DMWr, n_mem_DMrd;
  logic [2:0] n_mem_DMCtrl;
  logic [4:0] n_mem_Rd;
  logic [1:0] n_wb_RUDatawrSrc;
  logic       n_wb_RuWr;
  logic [4:0] n_wb_Rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cunit_pipe #(.MEXT(1), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7),
    .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .flush(flush),
    .id_ImmSrc(id_ImmSrc), .id_illegal(id_illegal), .stall_if_id(stall_if_id),
    .ex_busy(ex_busy), .ex_ALUASrc(ex_ALUASrc), .ex_ALUBSrc(ex_ALUBSrc),
    .ex_ALUOp(ex_ALUOp), .ex_BUOp(ex_BUOp), .ex_Rd(ex_Rd),
    .mem_DMWr(mem_DMWr), .mem_DMrd(mem_DMrd), .mem_DMCtrl(mem_DMCtrl), .mem_Rd(mem_Rd),
    .wb_RUDatawrSrc(wb_RUDatawrSrc), .wb_RuWr(wb_RuWr), .wb_Rd(wb_Rd));

  // Same stream, no M extension.
  cunit_pipe #(.MEXT(0), .DIV_LAT(1)) dut_nm (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Funct3(Funct3), .Funct7(Funct7),
    .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .flush(flush),
    .id_ImmSrc(n_id_ImmSrc), .id_illegal(n_id_illegal), .stall_if_id(n_stall_if_id),
    .ex_busy(n_ex_busy), .ex_ALUASrc(n_ex_ALUASrc), .ex_ALUBSrc(n_ex_ALUBSrc),
    .ex_ALUOp(n_ex_ALUOp), .ex_BUOp(n_ex_BUOp), .ex_Rd(n_ex_Rd),
    .mem_DMWr(n_mem_DMWr), .mem_DMrd(n_mem_DMrd), .mem_DMCtrl(n_mem_DMCtrl), .mem_Rd(n_mem_Rd),
    .wb_RUDatawrSrc(n_wb_RUDatawrSrc), .wb_RuWr(n_wb_RuWr), .wb_Rd(n_wb_Rd));

  wire [16:0] ex_vec  = {ex_ALUASrc, ex_ALUBSrc, ex_ALUOp, ex_BUOp, ex_Rd};
  wire [9:0]  mem_vec = {mem_DMWr, mem_DMrd, mem_DMCtrl, mem_Rd};
  wire [7:0]  wb_vec  = {wb_RUDatawrSrc, wb_RuWr, wb_Rd};

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] imm;
    logic       asrc, bsrc;
    logic [4:0] aluop;
    logic       dmwr;
    logic [2:0] dmctrl;
    logic [1:0] wrsrc;
    logic       ruwr;
    logic [4:0] buop;
    logic       dmrd;
    logic       use1, use2, isdiv, illegal;
  } dec_t;

  // One row per opcode: imm,asrc,bsrc,aluop,dmwr,dmctrl,wrsrc,ruwr,buop,dmrd,use1,use2,isdiv,illegal
  function automatic dec_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    dec_t d;
    case (op)
      OP_R:      d = (f7 == 7'b0000001)
                   ? {3'b000,2'b00,{2'b10,f3},1'b0,3'b000,2'b00,1'b1,5'b00000,1'b0,1'b1,1'b1,f3[2],1'b0}
                   : {3'b000,2'b00,{1'b0,f7[5],f3},1'b0,3'b000,2'b00,1'b1,5'b00000,1'b0,1'b1,1'b1,1'b0,1'b0};
      OP_I:      d = {3'b000,2'b01,{1'b0,(f3 == 3'b101) ? f7[5] : 1'b0,f3},1'b0,3'b000,2'b00,1'b1,5'b00000,1'b0,1'b1,1'b0,1'b0,1'b0};
      OP_LOAD:   d = {3'b000,2'b01,5'b00000,1'b0,f3,2'b01,1'b1,5'b00000,1'b1,1'b1,1'b0,1'b0,1'b0};
      OP_STORE:  d = {3'b001,2'b01,5'b00000,1'b1,f3,2'b00,1'b0,5'b00000,1'b0,1'b1,1'b1,1'b0,1'b0};
      OP_BRANCH: d = {3'b101,2'b11,5'b00000,1'b0,3'b000,2'b00,1'b0,{2'b01,f3},1'b0,1'b1,1'b1,1'b0,1'b0};
      OP_JAL:    d = {3'b110,2'b11,5'b00000,1'b0,3'b000,2'b10,1'b1,5'b10000,1'b0,1'b0,1'b0,1'b0,1'b0};
      OP_JALR:   d = {3'b000,2'b01,5'b00000,1'b0,3'b000,2'b10,1'b1,5'b10000,1'b0,1'b1,1'b0,1'b0,1'b0};
      OP_LUI:    d = {3'b011,2'b11,5'b01111,1'b0,3'b000,2'b00,1'b1,5'b00000,1'b0,1'b0,1'b0,1'b0,1'b0};
      OP_AUIPC:  d = {3'b011,2'b11,5'b00000,1'b0,3'b000,2'b00,1'b1,5'b00000,1'b0,1'b0,1'b0,1'b0,1'b0};
      default:   d = {26'd0, 1'b1};
    endcase
    return d;
  endfunction

  // Control word of one in-flight instruction; a bubble is all zero.
  typedef struct packed {
    logic       asrc, bsrc;
    logic [4:0] aluop, buop;
    logic       dmwr, dmrd;
    logic [2:0] dmctrl;
    logic [1:0] wrsrc;
    logic       ruwr;
    logic [4:0] rd;
  } ctl_t;

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input logic fl);
    @(negedge clk);
    OpCode = op; Funct3 = f3; Funct7 = f7; Rs1 = r1; Rs2 = r2; Rd = rd; flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(7'h00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    checks++;
    if ({ex_vec, mem_vec, wb_vec, ex_busy, stall_if_id} !== '0) begin
      errors++;
      $display("FAIL reset_state got ex=%h mem=%h wb=%h busy=%b stall=%b want all 0",
               ex_vec, mem_vec, wb_vec, ex_busy, stall_if_id);
    end
    rst = 1'b0;
    drive(OP_R, 3'b100, 7'b0000001, 5'd1, 5'd2, 5'd6, 1'b0);   // div x6
    idle();
    idle();
    checks++;
    if (ex_busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got %b want 1", ex_busy); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ex_vec, mem_vec, wb_vec, ex_busy} !== '0) begin
      errors++;
      $display("FAIL reset_async got ex=%h mem=%h wb=%h busy=%b want all 0", ex_vec, mem_vec, wb_vec, ex_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(OP_R, 3'b000, 7'd0, 5'd1, 5'd2, 5'd5, 1'b0);         // add x5
    idle();
    checks++;
    if (ex_Rd !== 5'd5) begin errors++; $display("FAIL reset_first_ex got rd=%0d want 5", ex_Rd); end
    idle();
    idle();
    checks++;
    if ({wb_RuWr, wb_Rd} !== {1'b1, 5'd5}) begin
      errors++; $display("FAIL reset_first_wb got ruwr=%b rd=%0d want 1/5", wb_RuWr, wb_Rd);
    end
  endtask

  task automatic test_load_use();
    drive(OP_LOAD, 3'b010, 7'd0, 5'd1, 5'd0, 5'd3, 1'b0);     // lw x3
    drive(OP_R, 3'b000, 7'd0, 5'd3, 5'd1, 5'd4, 1'b0);        // add x4,x3,x1
    checks++;
    if (stall_if_id !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall_if_id); end
    drive(OP_R, 3'b000, 7'd0, 5'd3, 5'd1, 5'd4, 1'b0);        // held in ID
    checks++;
    if ({stall_if_id, ex_ALUOp, ex_Rd, mem_DMrd} !== {1'b0, 5'd0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL lu_bubble got stall=%b aluop=%b rd=%0d memrd=%b want 0/00000/0/1",
               stall_if_id, ex_ALUOp, ex_Rd, mem_DMrd);
    end
    idle();
    checks++;
    if (ex_Rd !== 5'd4) begin errors++; $display("FAIL lu_resume got rd=%0d want 4", ex_Rd); end
    drive(OP_LOAD, 3'b010, 7'd0, 5'd1, 5'd0, 5'd0, 1'b0);     // lw x0
    drive(OP_R, 3'b000, 7'd0, 5'd0, 5'd0, 5'd4, 1'b0);
    checks++;
    if (stall_if_id !== 1'b0) begin errors++; $display("FAIL lu_x0 got stall=%b want 0", stall_if_id); end
    idle();
    checks++;
    if (ex_Rd !== 5'd4) begin errors++; $display("FAIL lu_x0_pass got rd=%0d want 4", ex_Rd); end
  endtask

  task automatic test_div();
    int busy_cnt = 0;
    int bub_cnt  = 0;
    drive(OP_R, 3'b100, 7'b0000001, 5'd1, 5'd2, 5'd7, 1'b0);  // div x7
    checks++;
    if (n_id_illegal !== 1'b1) begin errors++; $display("FAIL nomext_illegal got %b want 1", n_id_illegal); end
    for (int i = 1; i <= DIV_LAT + 2; i++) begin
      drive(OP_R, 3'b000, 7'd0, 5'd10, 5'd11, 5'd8, 1'b0);    // add x8 waits in ID
      if (ex_busy === 1'b1) begin
        busy_cnt++;
        checks++;
        if ({ex_ALUOp, ex_Rd, stall_if_id} !== {5'b10100, 5'd7, 1'b1}) begin
          errors++;
          $display("FAIL div_hold cyc=%0d got aluop=%b rd=%0d stall=%b want 10100/7/1", i, ex_ALUOp, ex_Rd, stall_if_id);
        end
      end
      if (i >= 2 && i <= DIV_LAT && mem_vec === '0) bub_cnt++;
      if (i == 1) begin
        checks++;
        if ({n_ex_ALUOp, n_ex_Rd} !== 10'd0) begin
          errors++; $display("FAIL nomext_bubble got aluop=%b rd=%0d want 0/0", n_ex_ALUOp, n_ex_Rd);
        end
      end
      if (i == DIV_LAT + 1) begin
        checks++;
        if ({mem_Rd, ex_Rd} !== {5'd7, 5'd8}) begin
          errors++; $display("FAIL div_advance got mem_rd=%0d ex_rd=%0d want 7/8", mem_Rd, ex_Rd);
        end
      end
    end
    checks++;
    if (busy_cnt != DIV_LAT - 1) begin errors++; $display("FAIL div_busy_cycles got %0d want %0d", busy_cnt, DIV_LAT - 1); end
    checks++;
    if (bub_cnt != DIV_LAT - 1) begin errors++; $display("FAIL div_mem_bubbles got %0d want %0d", bub_cnt, DIV_LAT - 1); end
  endtask

  task automatic test_flush();
    logic sw_seen = 1'b0;
    drive(OP_BRANCH, 3'b000, 7'd0, 5'd1, 5'd2, 5'd0, 1'b0);   // beq
    drive(OP_STORE, 3'b010, 7'd0, 5'd1, 5'd2, 5'd0, 1'b1);    // sw in ID, branch taken
    for (int i = 0; i < 4; i++) begin
      idle();
      sw_seen |= mem_DMWr;
    end
    checks++;
    if (sw_seen !== 1'b0) begin errors++; $display("FAIL flush_sw got memwr_seen=%b want 0", sw_seen); end
    drive(OP_LOAD, 3'b010, 7'd0, 5'd1, 5'd0, 5'd3, 1'b0);     // lw x3
    drive(OP_R, 3'b000, 7'd0, 5'd3, 5'd1, 5'd4, 1'b1);        // add x4,x3 with flush
    checks++;
    if (stall_if_id !== 1'b0) begin errors++; $display("FAIL flush_lu_stall got %b want 0", stall_if_id); end
    drive(OP_R, 3'b000, 7'd0, 5'd1, 5'd2, 5'd6, 1'b0);        // next fetched instr
    checks++;
    if ({ex_ALUOp, ex_Rd, stall_if_id} !== 11'd0) begin
      errors++; $display("FAIL flush_bubble got aluop=%b rd=%0d stall=%b want 0/0/0", ex_ALUOp, ex_Rd, stall_if_id);
    end
    idle();
    checks++;
    if (ex_Rd !== 5'd6) begin errors++; $display("FAIL flush_single got rd=%0d want 6", ex_Rd); end
  endtask

  task automatic test_flush_busy();
    drive(OP_R, 3'b101, 7'b0000001, 5'd1, 5'd2, 5'd7, 1'b0);  // divu x7
    for (int i = 1; i <= DIV_LAT + 2; i++) begin
      drive(OP_R, 3'b000, 7'd0, 5'd10, 5'd11, 5'd9, i == 3);
      if (i == DIV_LAT) begin
        checks++;
        if ({ex_busy, stall_if_id, ex_Rd} !== {1'b0, 1'b0, 5'd7}) begin
          errors++; $display("FAIL fb_fall got busy=%b stall=%b rd=%0d want 0/0/7", ex_busy, stall_if_id, ex_Rd);
        end
      end
      if (i == DIV_LAT + 1) begin
        checks++;
        if ({ex_Rd, mem_Rd} !== {5'd0, 5'd7}) begin
          errors++; $display("FAIL fb_bubble got ex_rd=%0d mem_rd=%0d want 0/7", ex_Rd, mem_Rd);
        end
      end
      if (i == DIV_LAT + 2) begin
        checks++;
        if (ex_Rd !== 5'd9) begin errors++; $display("FAIL fb_cleared got ex_rd=%0d want 9", ex_Rd); end
      end
    end
  endtask

  task automatic test_misc();
    drive(OP_JALR, 3'b000, 7'd0, 5'd2, 5'd0, 5'd1, 1'b0);     // jalr x1
    idle();
    checks++;
    if ({ex_BUOp, ex_ALUBSrc} !== {5'b10000, 1'b1}) begin
      errors++; $display("FAIL jalr_ex got buop=%b bsrc=%b want 10000/1", ex_BUOp, ex_ALUBSrc);
    end
    idle();
    idle();
    checks++;
    if (wb_vec !== {2'b10, 1'b1, 5'd1}) begin
      errors++; $display("FAIL jalr_wb got src=%b ruwr=%b rd=%0d want 10/1/1", wb_RUDatawrSrc, wb_RuWr, wb_Rd);
    end
    drive(OP_LUI, 3'b011, 7'h55, 5'd3, 5'd4, 5'd5, 1'b0);
    checks++;
    if (id_ImmSrc !== 3'b011) begin errors++; $display("FAIL lui_imm got %b want 011", id_ImmSrc); end
    idle();
    checks++;
    if (ex_ALUOp !== 5'b01111) begin errors++; $display("FAIL lui_aluop got %b want 01111", ex_ALUOp); end
    drive(7'b1010101, 3'b111, 7'h7f, 5'd1, 5'd2, 5'd9, 1'b0);
    checks++;
    if ({id_illegal, id_ImmSrc} !== {1'b1, 3'b000}) begin
      errors++; $display("FAIL illegal_id got ill=%b imm=%b want 1/000", id_illegal, id_ImmSrc);
    end
    idle();
    checks++;
    if (ex_vec !== '0) begin errors++; $display("FAIL illegal_bubble got ex=%h want 0", ex_vec); end
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{OP_R, OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, 7'b1111111};
    logic [6:0] f7s [4]  = '{7'h00, 7'h20, 7'h01, 7'h01};
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] r1, r2, rd;
    logic       fl, hold, kill, haz, busy_m, exp_stall, pend;
    ctl_t       pipe [3];               // EX, MEM, WB occupants
    int         ex_left;                // cycles the EX occupant still spends in EX
    dec_t       d;
    ctl_t       c;

    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    ex_left = 1; pend = 1'b0; hold = 1'b0;
    op = '0; f3 = '0; f7 = '0; r1 = '0; r2 = '0; rd = '0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold) begin
        op = ops[$urandom_range(0, 9)];
        f3 = 3'($urandom_range(0, 7));
        f7 = ($urandom_range(0, 4) == 4) ? 7'($urandom) : f7s[$urandom_range(0, 3)];
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
      end
      fl = ($urandom_range(0, 7) == 0);
      drive(op, f3, f7, r1, r2, rd, fl);

      d         = ref_decode(op, f3, f7);
      busy_m    = (ex_left > 1);
      kill      = fl || pend;
      haz       = pipe[0].dmrd && pipe[0].rd != 0 &&
                  ((d.use1 && r1 == pipe[0].rd) || (d.use2 && r2 == pipe[0].rd));
      exp_stall = busy_m || (haz && !kill);

      checks++;
      if ({id_ImmSrc, id_illegal, stall_if_id, ex_busy} !== {d.illegal ? 3'b000 : d.imm, d.illegal, exp_stall, busy_m}) begin
        errors++;
        $display("FAIL rnd_id cyc=%0d got imm=%b ill=%b stall=%b busy=%b want %b/%b/%b/%b", cyc,
                 id_ImmSrc, id_illegal, stall_if_id, ex_busy, d.imm, d.illegal, exp_stall, busy_m);
      end
      checks++;
      if (ex_vec !== {pipe[0].asrc, pipe[0].bsrc, pipe[0].aluop, pipe[0].buop, pipe[0].rd}) begin
        errors++; $display("FAIL rnd_ex cyc=%0d got %h want %h", cyc, ex_vec,
                           {pipe[0].asrc, pipe[0].bsrc, pipe[0].aluop, pipe[0].buop, pipe[0].rd});
      end
      checks++;
      if (mem_vec !== {pipe[1].dmwr, pipe[1].dmrd, pipe[1].dmctrl, pipe[1].rd}) begin
        errors++; $display("FAIL rnd_mem cyc=%0d got %h want %h", cyc, mem_vec,
                           {pipe[1].dmwr, pipe[1].dmrd, pipe[1].dmctrl, pipe[1].rd});
      end
      checks++;
      if (wb_vec !== {pipe[2].wrsrc, pipe[2].ruwr, pipe[2].rd}) begin
        errors++; $display("FAIL rnd_wb cyc=%0d got %h want %h", cyc, wb_vec,
                           {pipe[2].wrsrc, pipe[2].ruwr, pipe[2].rd});
      end

      // Advance the model by one clock.
      hold    = exp_stall;
      pipe[2] = pipe[1];
      if (busy_m) begin
        pipe[1] = '0;
        ex_left = ex_left - 1;
        pend    = pend || fl;
      end else begin
        pipe[1] = pipe[0];
        pend    = 1'b0;
        if (kill || haz || d.illegal) begin
          pipe[0] = '0;
          ex_left = 1;
        end else begin
          c = '{asrc: d.asrc, bsrc: d.bsrc, aluop: d.aluop, buop: d.buop, dmwr: d.dmwr, dmrd: d.dmrd,
                dmctrl: d.dmctrl, wrsrc: d.wrsrc, ruwr: d.ruwr, rd: rd};
          pipe[0] = c;
          ex_left = d.isdiv ? DIV_LAT : 1;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_div();
    test_flush();
    test_flush_busy();
    test_misc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cunit_pipe.md
Name: cunit_pipe

Overview:
- Pipelined successor of the single-cycle RV32I control unit for the 5-stage core.
- Decodes the ID-stage instruction and carries its control word through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, applies branch/jump flush, and supports optional RV32M with a multi-cycle divider stall.

Parameters:
- MEXT, 1: 1 enables M-extension decode; 0 makes Funct7=0000001 R-type illegal.
- DIV_LAT, 8: EX occupancy in cycles for div/divu/rem/remu (legal range 1..32).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- OpCode  in  7  ID instruction [6:0]
- Funct3  in  3  ID instruction [14:12]
- Funct7  in  7  ID instruction [31:25]
- Rs1, Rs2, Rd  in  5 each  ID register fields
- flush  in  1  branch taken/jump, from the EX branch unit
- id_ImmSrc  out  3  combinational, feeds the ID immediate generator
- id_illegal  out  1  combinational, unsupported opcode/funct
- stall_if_id  out  1  hold PC and IF/ID
- ex_busy  out  1  divider occupying EX
- ex_ALUASrc, ex_ALUBSrc  out  1 each
- ex_ALUOp  out  5  {M, Funct7[5], Funct3}
- ex_BUOp  out  5
- ex_Rd  out  5
- mem_DMWr, mem_DMrd  out  1 each
- mem_DMCtrl  out  3
- mem_Rd  out  5
- wb_RUDatawrSrc  out  2
- wb_RuWr  out  1
- wb_Rd  out  5

Behaviour:
- Decode table (ImmSrc, ASrc, BSrc, ALUOp, DMWr, DMCtrl, WrSrc, RuWr, BUOp, DMrd):
  - R 0110011: 000, 0, 0, {0, F7[5], F3}, 0, 000, 00, 1, 00000, 0. M variant (F7=0000001, MEXT=1): ALUOp = {1, 0, F3}.
  - I 0010011: 000, 0, 1, {0, F3==101 ? F7[5] : 0, F3}, 0, 000, 00, 1, 00000, 0.
  - Load 0000011: 000, 0, 1, 0, 0, F3, 01, 1, 00000, 1.
  - Store 0100011: 001, 0, 1, 0, 1, F3, 00, 0, 00000, 0.
  - Branch 1100011: 101, 1, 1, 0, 0, 000, 00, 0, {01, F3}, 0.
  - JAL 1101111: 110, 1, 1, 0, 0, 000, 10, 1, 10000, 0.
  - JALR 1100111: 000, 0, 1, 0, 0, 000, 10, 1, 10000, 0 (writes link register).
  - LUI 0110111: 011, 1, 1, 01111 (pass B), 0, 000, 00, 1, 00000, 0.
  - AUIPC 0010111: 011, 1, 1, 0, 0, 000, 00, 1, 00000, 0.
  - Other: id_illegal=1, id_ImmSrc=000; a bubble (all-zero control, Rd=0) enters EX.
- Bubble: all control fields and Rd zero.
- Reset: all pipeline registers set to bubble; div counter=0; pending_flush=0; stall_if_id=0; ex_busy=0.
- Normal flow: one stage per clk. EX fields are valid one cycle after ID decode, MEM two, WB three.
- Load-use: if ex_DMrd=1, ex_Rd!=0, and ex_Rd matches a used source, then stall_if_id=1 (combinational) and a bubble enters EX for exactly one cycle.
  - Rs1 is used by R, I, Load, Store, Branch, JALR.
  - Rs2 is used by R, Store, Branch.
- Divider:
  - When an M op with F3[2]=1 is latched into EX, the counter loads DIV_LAT-1.
  - While counter!=0: ex_busy=1, stall_if_id=1, the EX register holds, a bubble enters MEM, and the counter decrements.
  - At counter==0 the op advances normally.
  - DIV_LAT=1 means no stall. mul* ops never stall.
- Flush with ex_busy=0: the ID instruction is replaced by a bubble into EX. Flush takes priority over the load-use stall, so no bubble is doubled and stall_if_id=0 that cycle.
- Flush with ex_busy=1: pending_flush is set. It is applied in the first cycle with ex_busy=0, then cleared.
- Reset mid-divide: the counter clears immediately (asynchronous) and the held op is discarded.
- Writes with Rd=0 propagate unchanged; the register file ignores x0.

Test Plan:
- Reset pulse mid-stream → all ex_/mem_/wb_ outputs 0 asynchronously, ex_busy=0; first post-reset R add (F7=0, F3=000, Rd=5) → wb_RuWr=1, wb_Rd=5 three cycles after ID.
- lw x3 then add x4,x3,x1 back-to-back → stall_if_id=1 for exactly one cycle, ex_ALUOp=0 with ex_Rd=0 that cycle, add reaches EX next cycle; with Rd=x0 → no stall.
- div (F7=0000001, F3=100), DIV_LAT=8 → ex_busy=1 for 7 cycles, mem gets 7 bubbles, ex_ALUOp=10100 held; with MEXT=0 → id_illegal=1 and bubble.
- beq taken: flush=1 with sw in ID → sw never reaches MEM (mem_DMWr stays 0); flush with load-use condition → stall_if_id=0.
- flush during div busy (cycle 3 of 7) → ID instruction bubbled in the cycle ex_busy falls; pending_flush clears.
- jalr x1 → wb_RuWr=1, wb_RUDatawrSrc=10, ex_BUOp=10000; lui → id_ImmSrc=011, ex_ALUOp=01111; opcode 1010101 → id_illegal=1.
